// File: rtl/ew_gate_pkg.sv
// Shared types, default sizes and helpers for the element-wise gating pipe.
package ew_gate_pkg;

  localparam int unsigned DEF_TILE_SIZE   = 4;
  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_G_FRAC_BITS = 8;
  localparam int unsigned DEF_D           = 256;
  localparam int unsigned DEF_SAT_CNT_W   = 16;

  // Wide signed working width for rounding; holds any product of lanes up to 31 bits.
  localparam int unsigned WIDE_W = 64;

  typedef logic signed [DEF_DATA_WIDTH-1:0]   lane_t;
  typedef logic signed [2*DEF_DATA_WIDTH-1:0] prod_t;
  typedef logic signed [WIDE_W-1:0]           wide_t;

  // Counter width helper: $clog2 with a floor of 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TILES_PER_VEC = DEF_D / DEF_TILE_SIZE;
  localparam int unsigned TCNT_W        = cnt_width(TILES_PER_VEC);

  // Round-half-up then arithmetic shift right by frac bits.
  function automatic wide_t round_shift(input wide_t p, input int unsigned frac);
    wide_t half;
    half = wide_t'(1) <<< (frac - 1);
    return (p + half) >>> frac;
  endfunction

endpackage

// File: rtl/ew_gate_lane.sv
// One gating lane: round/shift a product back to lane width, optionally clamping.
// Clamp behaviour selected by EW_GATE_SAT_EN (undefined: two's-complement wrap).
module ew_gate_lane
  import ew_gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned G_FRAC_BITS = DEF_G_FRAC_BITS
) (
  input  logic signed [2*DATA_WIDTH-1:0] p,
  output logic signed [DATA_WIDTH-1:0]   y_lane,
  output logic                           sat_flag
);

  wide_t r;

  assign r = round_shift(WIDE_W'(p), G_FRAC_BITS);

`ifdef EW_GATE_SAT_EN
  localparam wide_t LANE_MAX = (wide_t'(1) <<< (DATA_WIDTH - 1)) - wide_t'(1);
  localparam wide_t LANE_MIN = -(wide_t'(1) <<< (DATA_WIDTH - 1));

  // Clamp out-of-range results and flag the lane.
  always_comb begin
    y_lane   = r[DATA_WIDTH-1:0];
    sat_flag = 1'b0;
    if (r > LANE_MAX) begin
      y_lane   = LANE_MAX[DATA_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (r < LANE_MIN) begin
      y_lane   = LANE_MIN[DATA_WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end
`else
  // Upper result bits are intentionally dropped by the wrap.
  logic unused_r_hi;
  assign unused_r_hi = ^r[WIDE_W-1:DATA_WIDTH];
  assign y_lane      = r[DATA_WIDTH-1:0];
  assign sat_flag    = 1'b0;
`endif

endmodule

// File: rtl/ew_gate_stream_pipe.sv
// Two-stage element-wise gate: y = sat/wrap(round(a*g >> G_FRAC_BITS)) per lane,
// AXI-stream join of a/g, TLAST every D elements, saturation event counter.
// Optional clamping enabled by defining EW_GATE_SAT_EN.
module ew_gate_stream_pipe
  import ew_gate_pkg::*;
#(
  parameter int unsigned TILE_SIZE   = DEF_TILE_SIZE,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned G_FRAC_BITS = DEF_G_FRAC_BITS,
  parameter int unsigned D           = DEF_D,
  parameter int unsigned SAT_CNT_W   = DEF_SAT_CNT_W
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        a_axis_TVALID,
  output logic                                        a_axis_TREADY,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] a_axis_TDATA,
  input  logic                                        g_axis_TVALID,
  output logic                                        g_axis_TREADY,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] g_axis_TDATA,
  output logic                                        y_axis_TVALID,
  input  logic                                        y_axis_TREADY,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] y_axis_TDATA,
  output logic                                        y_axis_TLAST,
  output logic        [SAT_CNT_W-1:0]                 sat_cnt
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned TILES  = D / TILE_SIZE;
  localparam int unsigned CNT_W  = cnt_width(TILES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TILES - 1);

  // Elaboration-time parameter checks.
  if (D % TILE_SIZE != 0) begin : g_bad_d
    $error("ew_gate_stream_pipe: D must be a multiple of TILE_SIZE");
  end
  if (G_FRAC_BITS < 1 || G_FRAC_BITS >= PROD_W - 1) begin : g_bad_frac
    $error("ew_gate_stream_pipe: G_FRAC_BITS out of range");
  end
  if (PROD_W + 1 > WIDE_W) begin : g_bad_width
    $error("ew_gate_stream_pipe: DATA_WIDTH too large for rounding width");
  end

  logic                                 s1_valid_q;
  logic [TILE_SIZE-1:0][PROD_W-1:0]     s1_prod_q;
  logic [TILE_SIZE-1:0][PROD_W-1:0]     prod_d;
  logic                                 y_valid_q;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] y_data_q;
  logic                                 y_last_q;
  logic [CNT_W-1:0]                     tcnt_q;
  logic [CNT_W-1:0]                     load_idx;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] lane_y;
  logic [TILE_SIZE-1:0]                 lane_sat;

  logic s1_ready;
  logic s2_ready;
  logic join_fire;
  logic s2_load;
  logic y_hs;

  assign s2_ready  = !y_valid_q || y_axis_TREADY;
  assign s1_ready  = !s1_valid_q || s2_ready;
  assign join_fire = a_axis_TVALID && g_axis_TVALID && s1_ready;
  assign s2_load   = s1_valid_q && s2_ready;
  assign y_hs      = y_valid_q && y_axis_TREADY;

  assign a_axis_TREADY = join_fire;
  assign g_axis_TREADY = join_fire;

  // Per-lane signed product of the joined tiles.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < int'(TILE_SIZE); i++) begin
      prod_d[i] = PROD_W'($signed(a_axis_TDATA[i])) * PROD_W'($signed(g_axis_TDATA[i]));
    end
  end

  for (genvar i = 0; i < int'(TILE_SIZE); i++) begin : g_lane
    ew_gate_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .G_FRAC_BITS (G_FRAC_BITS)
    ) u_lane (
      .p        ($signed(s1_prod_q[i])),
      .y_lane   (lane_y[i]),
      .sat_flag (lane_sat[i])
    );
  end

  // Index of the tile entering S2: one past the occupant if S2 is handing it off.
  always_comb begin
    load_idx = tcnt_q;
    if (y_valid_q) begin
      load_idx = (tcnt_q == LAST_IDX) ? '0 : tcnt_q + CNT_W'(1);
    end
  end

  // S1: product register; refills in the same cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
    end else if (join_fire) begin
      s1_valid_q <= 1'b1;
      s1_prod_q  <= prod_d;
    end else if (s2_ready) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2: output register with TLAST, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
    end else if (s2_load) begin
      y_valid_q <= 1'b1;
      y_data_q  <= lane_y;
      y_last_q  <= (load_idx == LAST_IDX);
    end else if (y_axis_TREADY) begin
      y_valid_q <= 1'b0;
    end
  end

  // Tile-in-vector counter, advanced per output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (y_hs) begin
      tcnt_q <= (tcnt_q == LAST_IDX) ? '0 : tcnt_q + CNT_W'(1);
    end
  end

`ifdef EW_GATE_SAT_EN
  localparam int unsigned NSAT_W = cnt_width(TILE_SIZE + 1);
  localparam int unsigned SUM_W  = SAT_CNT_W + NSAT_W;
  localparam logic [SAT_CNT_W-1:0] SAT_MAX = '1;

  logic [SAT_CNT_W-1:0] sat_cnt_q;
  logic [SAT_CNT_W-1:0] sat_cnt_d;
  logic [NSAT_W-1:0]    nsat;
  logic [SUM_W-1:0]     sat_sum;

  // Count clamped lanes of the loading tile; stick at all-ones.
  always_comb begin
    nsat = '0;
    for (int i = 0; i < int'(TILE_SIZE); i++) begin
      nsat = nsat + NSAT_W'(lane_sat[i]);
    end
    sat_sum   = SUM_W'(sat_cnt_q) + SUM_W'(nsat);
    sat_cnt_d = (sat_sum > SUM_W'(SAT_MAX)) ? SAT_MAX : sat_sum[SAT_CNT_W-1:0];
  end

  // Saturation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (s2_load) begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = |lane_sat;
  assign sat_cnt    = '0;
`endif

  assign y_axis_TVALID = y_valid_q;
  assign y_axis_TDATA  = y_data_q;
  assign y_axis_TLAST  = y_last_q;

endmodule

// File: tb/tb_ew_gate_stream_pipe.sv
// Directed bench for ew_gate_stream_pipe with a scoreboard of expected output tiles.
module tb_ew_gate_stream_pipe;

  localparam int TS    = 4;
  localparam int DW    = 16;
  localparam int GF    = 8;
  localparam int DD    = 256;
  localparam int TILES = DD / TS;

  logic clk = 1'b0;
  logic rst_n;
  logic a_v, g_v, y_r;
  logic a_rdy, g_rdy, y_v, y_last;
  logic [TS-1:0][DW-1:0] a_d, g_d, y_d;
  logic [15:0] sat_cnt;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          join_cnt = 0;
  int          last_seen = 0;
  int          idx = 0;
  logic [15:0] exp_sat = '0;

  always #5 clk = ~clk;

  ew_gate_stream_pipe #(
    .TILE_SIZE(TS), .DATA_WIDTH(DW), .G_FRAC_BITS(GF), .D(DD), .SAT_CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_axis_TVALID(a_v), .a_axis_TREADY(a_rdy), .a_axis_TDATA(a_d),
    .g_axis_TVALID(g_v), .g_axis_TREADY(g_rdy), .g_axis_TDATA(g_d),
    .y_axis_TVALID(y_v), .y_axis_TREADY(y_r), .y_axis_TDATA(y_d),
    .y_axis_TLAST(y_last), .sat_cnt(sat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision product, round-half-up, then clamp or wrap.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] g,
                                        output int nsat);
    longint av, gv, p, r;
    logic [15:0] a16, g16;
    logic [63:0] res;
    nsat = 0;
    res  = '0;
    for (int i = 0; i < TS; i++) begin
      a16 = a[16*i +: 16];
      g16 = g[16*i +: 16];
      av  = longint'($signed(a16));
      gv  = longint'($signed(g16));
      p   = av * gv;
      r   = (p + (longint'(1) << (GF - 1))) >>> GF;
`ifdef EW_GATE_SAT_EN
      if (r > 32767) begin
        r = 32767;
        nsat++;
      end else if (r < -32768) begin
        r = -32768;
        nsat++;
      end
`endif
      res[16*i +: 16] = r[15:0];
    end
    return res;
  endfunction

  // Pushes expected tiles at joins, pops and compares at y handshakes.
  task automatic monitor_loop();
    exp_t e;
    int   ns;
    int   s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        idx     = 0;
        exp_sat = '0;
      end else begin
        if (y_v && y_r) begin
          if (y_last) last_seen++;
          check("sb_nonempty_at_output", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("y_data", 64'(y_d), e.data);
            check("y_last", 64'(y_last), 64'(e.last));
          end
        end
        if (a_rdy) begin
          check("g_tready_with_a", 64'(g_rdy), 64'd1);
          e.data  = model(64'(a_d), 64'(g_d), ns);
          e.last  = (idx == TILES - 1);
          idx     = (idx == TILES - 1) ? 0 : idx + 1;
          s       = int'(exp_sat) + ns;
          exp_sat = (s > 65535) ? 16'hFFFF : 16'(s);
          sb.push_back(e);
          join_cnt++;
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] av, input logic [63:0] gv);
    bit ok = 1'b0;
    a_d = av;
    g_d = gv;
    a_v = 1'b1;
    g_v = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (a_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_v = 1'b0;
    g_v = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0 && !y_v) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int          j0, jl, l0;
    logic [63:0] snap;
    logic [63:0] sat_exp_y;
    logic [15:0] sat_exp_cnt;

    rst_n = 1'b0;
    a_v = 1'b0; g_v = 1'b0; y_r = 1'b1;
    a_d = '0;   g_d = '0;
    fork
      monitor_loop();
    join_none

    // Reset state
    #1;
    check("rst_y_valid", 64'(y_v), 64'd0);
    check("rst_y_data", 64'(y_d), 64'd0);
    check("rst_y_last", 64'(y_last), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("rst_a_ready", 64'(a_rdy), 64'd0);
    check("rst_g_ready", 64'(g_rdy), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 1.0 * 0.5 with two-cycle latency
    send({4{16'h0100}}, {4{16'h0080}});
    check("lat_one_edge", 64'(y_v), 64'd0);
    idle();
    @(posedge clk);
    #1;
    check("lat_two_edges", 64'(y_v), 64'd1);
    check("basic_y", 64'(y_d), {4{16'h0080}});
    drain();

    // Rounding and sign
    send({4{16'h0001}}, {4{16'h0080}});
    send({4{16'hFFFF}}, {4{16'h0080}});
    send({4{16'hFFFE}}, {4{16'h0180}});
    idle();
    drain();

    // Saturation
`ifdef EW_GATE_SAT_EN
    sat_exp_y   = {4{16'h7FFF}};
    sat_exp_cnt = 16'd4;
`else
    sat_exp_y   = {4{16'hFFFE}};
    sat_exp_cnt = 16'd0;
`endif
    send({4{16'h7FFF}}, {4{16'h0200}});
    idle();
    @(posedge clk);
    #1;
    check("sat_y", 64'(y_d), sat_exp_y);
    drain();
    check("sat_cnt_abs", 64'(sat_cnt), 64'(sat_exp_cnt));

    // Mixed lanes and random tiles, back-to-back
    send({16'h7FFF, 16'hFFFE, 16'hFFFF, 16'h0001}, {16'h0200, 16'h0180, 16'h0080, 16'h0080});
    for (int i = 0; i < 12; i++) send(rnd64(), rnd64());
    idle();
    drain();
    check("sat_cnt_model", 64'(sat_cnt), 64'(exp_sat));

    // Backpressure: inputs always valid, output stalled for 10 cycles
    y_r  = 1'b0;
    j0   = join_cnt;
    jl   = join_cnt;
    snap = '0;
    a_d  = rnd64();
    g_d  = rnd64();
    a_v  = 1'b1;
    g_v  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (join_cnt != jl) begin
        jl  = join_cnt;
        a_d = rnd64();
        g_d = rnd64();
      end
      if (i == 3) snap = 64'(y_d);
    end
    check("bp_joins", 64'(join_cnt - j0), 64'd2);
    check("bp_y_stable", 64'(y_d), snap);
    check("bp_y_valid", 64'(y_v), 64'd1);
    check("bp_in_stalled", 64'(a_rdy), 64'd0);
    idle();
    y_r = 1'b1;
    drain();

    // Join skew: a valid alone transfers nothing
    j0  = join_cnt;
    a_d = rnd64();
    a_v = 1'b1;
    g_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("skew_a_ready", 64'(a_rdy), 64'd0);
    end
    check("skew_no_join", 64'(join_cnt - j0), 64'd0);
    send(64'(a_d), rnd64());
    idle();
    check("skew_one_join", 64'(join_cnt - j0), 64'd1);
    drain();

    // Framing from a fresh vector: 64 tiles then a 65th
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    l0 = last_seen;
    for (int i = 0; i < TILES + 1; i++) send(rnd64(), rnd64());
    idle();
    drain();
    check("frame_last_count", 64'(last_seen - l0), 64'd1);

    // Asynchronous reset mid-stream, then vector index restarts
    for (int i = 0; i < 5; i++) send(rnd64(), rnd64());
    #2;
    rst_n = 1'b0;
    a_v   = 1'b0;
    g_v   = 1'b0;
    #1;
    check("mid_rst_y_valid", 64'(y_v), 64'd0);
    check("mid_rst_y_data", 64'(y_d), 64'd0);
    check("mid_rst_y_last", 64'(y_last), 64'd0);
    check("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("mid_rst_a_ready", 64'(a_rdy), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    l0 = last_seen;
    for (int i = 0; i < TILES; i++) send(rnd64(), rnd64());
    idle();
    drain();
    check("post_rst_last_count", 64'(last_seen - l0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ew_gate_stream_pipe.md
# ew_gate_stream_pipe

Parametrised element-wise gating stage for the MAC, bias, FIFO, sigmoid and gate datapath. It joins two tile streams and multiplies them lane by lane: `a` is the activation tile and `g` is the gate tile from the sigmoid LUT. Each product is rounded, shifted and optionally saturated back to DATA_WIDTH. It replaces the fixed 4-lane gate, adding configurable lane count, a two-stage backpressure-aware pipeline, TLAST framing per D-element vector and a saturation event counter.

## Interface
- TILE_SIZE, 4: lanes per tile (any value ≥1).
- DATA_WIDTH, 16: signed lane width of a, g and y.
- G_FRAC_BITS, 8: fractional bits of g. Must satisfy 1 ≤ G_FRAC_BITS < 2*DATA_WIDTH-1.
- D, 256: elements per vector. D % TILE_SIZE != 0 raises `$error` at elaboration.
- SAT_CNT_W, 16: width of the saturation counter.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- a_axis_TVALID  in  1  activation tile valid.
- a_axis_TREADY  out  1  activation tile ready.
- a_axis_TDATA  in  signed [DATA_WIDTH-1:0] [TILE_SIZE-1:0]  activation lanes.
- g_axis_TVALID  in  1  gate tile valid.
- g_axis_TREADY  out  1  gate tile ready.
- g_axis_TDATA  in  signed [DATA_WIDTH-1:0] [TILE_SIZE-1:0]  gate lanes, Q(G_FRAC_BITS).
- y_axis_TVALID  out  1  result valid.
- y_axis_TREADY  in  1  downstream ready.
- y_axis_TDATA  out  signed [DATA_WIDTH-1:0] [TILE_SIZE-1:0]  result lanes.
- y_axis_TLAST  out  1  high on the last tile of each D-element vector.
- sat_cnt  out  SAT_CNT_W  number of saturated lanes; sticky at all-ones.

## Operation
- Join:
  - join_fire = a_TVALID & g_TVALID & s1_ready.
  - a_TREADY = g_TREADY = s1_ready & a_TVALID & g_TVALID. Neither input is consumed alone.
- Stage 1 (S1):
  - On join_fire, register the per-lane product p = a*g (signed, 2*DATA_WIDTH bits) and set s1_valid.
  - s1_ready = !s1_valid | s2_ready.
- Stage 2 (S2), the y output register:
  - Per lane, r = (p + 2^(G_FRAC_BITS-1)) >>> G_FRAC_BITS, an arithmetic shift giving round-half-up.
  - Narrow r to DATA_WIDTH as set by `## Configuration`.
  - s2_ready = !y_TVALID | y_TREADY.
- Tile counter:
  - Range 0..D/TILE_SIZE-1; advances on each y handshake (y_TVALID & y_TREADY) and wraps to 0.
  - y_TLAST is registered alongside y_TDATA. It is high when the loaded tile is the last of its vector, i.e. its index within the vector is D/TILE_SIZE-1. With D/TILE_SIZE = 1, TLAST is always high.
- sat_cnt:
  - Adds the number of saturating lanes in each tile as it loads into S2.
  - Clamps at 2^SAT_CNT_W-1 and never wraps.
- Backpressure:
  - While y_TVALID & !y_TREADY, y_TDATA and y_TLAST stay stable and S1 holds.
  - Inputs stall only when S1 is also full.

## Timing
- Reset (asynchronous, rst_n low): the following are all 0 immediately and independently of clk:
  - s1_valid, y_TVALID, y_TDATA, y_TLAST, the tile counter, sat_cnt;
  - a_TREADY and g_TREADY, which are combinational from valids that are now 0.
- Reset mid-operation discards in-flight tiles; the counter restarts at 0.
- Latency: y_TVALID rises 2 cycles after the join_fire edge.
- Throughput: 1 tile/cycle sustained while y_TREADY=1.
- Simultaneous events:
  - A full S1 accepts a new join in the same cycle it drains into S2.
  - A full S2 loads in the same cycle y handshakes.
- Capacity: 2 tiles in flight. After y_TREADY drops, at most 2 further joins are accepted.

## Configuration
- EW_GATE_SAT_EN defined:
  - r > 2^(DATA_WIDTH-1)-1 gives 2^(DATA_WIDTH-1)-1.
  - r < -2^(DATA_WIDTH-1) gives -2^(DATA_WIDTH-1).
  - Each clamped lane increments sat_cnt.
- EW_GATE_SAT_EN undefined:
  - y = r[DATA_WIDTH-1:0] (two's-complement wrap).
  - sat_cnt is tied to 0 and the clamp logic is absent.

## Structure
- Package ew_gate_pkg:
  - lane_t (signed DATA_WIDTH) and prod_t (signed 2*DATA_WIDTH);
  - function round_shift;
  - localparam TILES_PER_VEC = D/TILE_SIZE and TCNT_W = $clog2(TILES_PER_VEC) (minimum 1).
- Sub-module ew_gate_lane: combinational round, shift and saturate for one lane. Outputs are y_lane and sat_flag. It is instanced TILE_SIZE times by generate.

## Test plan
- Basic: TILE_SIZE=4, G_FRAC_BITS=8, all lanes a=0x0100 (1.0), g=0x0080 (0.5), y_TREADY=1 -> y=0x0080 on every lane, y_TVALID 2 cycles after join.
- Rounding and sign:
  - a=0x0001, g=0x0080 -> y=0x0001.
  - a=0xFFFF, g=0x0080 -> y=0x0000.
  - a=0xFFFE, g=0x0180 -> y=0xFFFD.
- Saturation: a=0x7FFF, g=0x0200:
  - with EW_GATE_SAT_EN -> y=0x7FFF and sat_cnt increments by 4;
  - without it -> y=0xFFFE and sat_cnt=0.
- Framing: D=256, 64 back-to-back tiles, then a 65th -> TLAST high only on tile 64; the 65th tile has TLAST=0.
- Backpressure:
  - Hold y_TREADY=0 for 10 cycles with a and g always valid -> exactly 2 joins are accepted and y_TDATA stays stable.
  - Release -> all tiles come out in order with none lost.
- Join skew and reset:
  - g_TVALID lags a_TVALID by 3 cycles -> no transfer until both are valid.
  - rst_n low mid-stream -> all outputs 0 asynchronously; after release the first tile's TLAST index restarts at 0.
